// File: rtl/mac_skew_feeder.sv
// mac_skew_feeder
// Holds one feature tile and one weight tile, then replays them into the
// 4x4 systolic MAC array in diagonal-skewed order. A zero-flush drain and a
// one-cycle done pulse follow each sequence. Every output is a register.
module mac_skew_feeder #(
    parameter  int DATA_W = 8,
    parameter  int N      = 4,
    parameter  int DRAIN  = 4,
    localparam int AW     = 2*$clog2(N)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic                       wr_sel,
    input  logic [AW-1:0]              wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       act_valid,
    output logic [N*DATA_W-1:0]        act_out,
    output logic [N*N*DATA_W-1:0]      w_out
);

    localparam int SW        = $clog2(2*N-1);
    localparam int DW        = (DRAIN < 1) ? 1 : $clog2(DRAIN+1);
    localparam int LAST_STEP = 2*N-2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [SW-1:0]           r_step;
    logic [SW-1:0]           w_stepNext;
    logic [DW-1:0]           r_drain;
    logic [DW-1:0]           w_drainNext;

    logic [DATA_W-1:0]       r_feat [N*N];
    logic [DATA_W-1:0]       r_wgt  [N*N];
    logic [DATA_W-1:0]       w_featNext [N*N];
    logic [DATA_W-1:0]       w_wgtNext  [N*N];

    logic [N*DATA_W-1:0]     r_actOut;
    logic [N*N*DATA_W-1:0]   r_wOut;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_actValid;

    logic [N*DATA_W-1:0]     w_actNext;
    logic [N*N*DATA_W-1:0]   w_wNext;
    logic                    w_busyNext;
    logic                    w_doneNext;
    logic                    w_actValidNext;

    // Tile contents as they will be after this edge; a write in IDLE is
    // merged here so a sequence started on the same edge already sees it.
    always_comb begin
        w_featNext = r_feat;
        w_wgtNext  = r_wgt;
        if (wr_en && (r_state == S_IDLE)) begin
            if (wr_sel) begin
                w_wgtNext[wr_addr] = wr_data;
            end else begin
                w_featNext[wr_addr] = wr_data;
            end
        end
    end

    // Tile storage; writes outside IDLE were already dropped above.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N*N; i++) begin
                r_feat[i] <= '0;
                r_wgt[i]  <= '0;
            end
        end else begin
            r_feat <= w_featNext;
            r_wgt  <= w_wgtNext;
        end
    end

    // Next-state logic: step and drain counters restart on every state change.
    always_comb begin
        w_stateNext = r_state;
        w_stepNext  = r_step;
        w_drainNext = r_drain;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_stateNext = S_FEED;
                end
            end
            S_FEED: begin
                if (r_step == SW'(LAST_STEP)) begin
                    w_stateNext = (DRAIN == 0) ? S_DONE : S_FLUSH;
                end else begin
                    w_stepNext = r_step + SW'(1);
                end
            end
            S_FLUSH: begin
                if (r_drain == DW'(DRAIN-1)) begin
                    w_stateNext = S_DONE;
                end else begin
                    w_drainNext = r_drain + DW'(1);
                end
            end
            S_DONE: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
        if (w_stateNext != r_state) begin
            w_stepNext  = '0;
            w_drainNext = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_stateNext;
            r_step  <= w_stepNext;
            r_drain <= w_drainNext;
        end
    end

    // Output values for the coming cycle, derived from the next state/step so
    // that they can be registered: lane r carries feat[r][t-r] on the
    // diagonal, and weight column t is revealed at step t and then held.
    always_comb begin
        w_actNext      = '0;
        w_wNext        = r_wOut;
        w_busyNext     = (w_stateNext == S_FEED) || (w_stateNext == S_FLUSH);
        w_doneNext     = (w_stateNext == S_DONE);
        w_actValidNext = (w_stateNext == S_FEED);
        if (w_stateNext == S_FEED) begin
            if (r_state == S_IDLE) begin
                w_wNext = '0;
            end
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (int'(w_stepNext) == r + c) begin
                        w_actNext[r*DATA_W +: DATA_W] = w_featNext[r*N+c];
                    end
                    if (int'(w_stepNext) == c) begin
                        w_wNext[(r*N+c)*DATA_W +: DATA_W] = w_wgtNext[r*N+c];
                    end
                end
            end
        end
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_actOut   <= '0;
            r_wOut     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_actValid <= 1'b0;
        end else begin
            r_actOut   <= w_actNext;
            r_wOut     <= w_wNext;
            r_busy     <= w_busyNext;
            r_done     <= w_doneNext;
            r_actValid <= w_actValidNext;
        end
    end

    assign act_out   = r_actOut;
    assign w_out     = r_wOut;
    assign busy      = r_busy;
    assign done      = r_done;
    assign act_valid = r_actValid;

endmodule
